// File: rtl/cdc_fifo_wptr_full_pkg.sv
// Pointer-code helpers shared by the write-side and read-side CDC FIFO pointer blocks.
// Functions work at the widest legal pointer width; callers zero-extend, then truncate.
package cdc_fifo_wptr_full_pkg;

    localparam int PTR_MAX_W = 13;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return (b >> 1) ^ b;
    endfunction

    // Prefix XOR from the MSB; zero-extended upper bits leave the result unchanged.
    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Generic two-flop synchronizer, reset to 0; latency 2 clk edges, no backpressure.
// The input is captured directly by the first flop with no logic in front of it.
module cdc_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1_q;
    logic [WIDTH-1:0] q2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= d;
            q2_q <= q1_q;
        end
    end

    assign q = q2_q;

endmodule

// File: rtl/cdc_fifo_wptr_full.sv
// Write-side pointer and full/almost-full flags of the async FIFO; flags assert on the filling edge,
// release 3 w_clk edges after a read. Writes requested while full are dropped (producer must stall).
module cdc_fifo_wptr_full
    import cdc_fifo_wptr_full_pkg::*;
#(
    parameter int ADDR_SIZE          = 4,
    parameter int ALMOST_FULL_MARGIN = 2
) (
    input  logic                 w_clk,
    input  logic                 w_rst_n,
    input  logic                 w_inc,
    input  logic [ADDR_SIZE:0]   r_ptr,
    output logic [ADDR_SIZE-1:0] w_addr,
    output logic [ADDR_SIZE:0]   w_ptr,
    output logic                 w_full,
    output logic                 w_almost_full
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    typedef logic [ADDR_SIZE:0] ptr_t;

    localparam ptr_t AF_THRESH = ptr_t'(DEPTH - ALMOST_FULL_MARGIN);

    ptr_t r_q2;
    ptr_t r_bin;
    ptr_t w_bin_q, w_bin_d;
    ptr_t w_ptr_q, w_ptr_d;
    ptr_t occ_d;
    logic w_full_q, w_full_d;
    logic w_af_q, w_af_d;

    cdc_sync2 #(
        .WIDTH (ADDR_SIZE + 1)
    ) u_rptr_sync (
        .clk   (w_clk),
        .rst_n (w_rst_n),
        .d     (r_ptr),
        .q     (r_q2)
    );

    // Flags are computed from the next pointer so the filling write raises them on its own edge.
    always_comb begin
        w_bin_d  = w_bin_q + {{ADDR_SIZE{1'b0}}, (w_inc & ~w_full_q)};
        w_ptr_d  = ptr_t'(bin2gray(ptr_max_t'(w_bin_d)));
        r_bin    = ptr_t'(gray2bin(ptr_max_t'(r_q2)));
        occ_d    = w_bin_d - r_bin;
        w_full_d = (w_ptr_d == {~r_q2[ADDR_SIZE:ADDR_SIZE-1], r_q2[ADDR_SIZE-2:0]});
        w_af_d   = (occ_d >= AF_THRESH);
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            w_bin_q  <= '0;
            w_ptr_q  <= '0;
            w_full_q <= 1'b0;
            w_af_q   <= 1'b0;
        end else begin
            w_bin_q  <= w_bin_d;
            w_ptr_q  <= w_ptr_d;
            w_full_q <= w_full_d;
            w_af_q   <= w_af_d;
        end
    end

    assign w_addr        = w_bin_q[ADDR_SIZE-1:0];
    assign w_ptr         = w_ptr_q;
    assign w_full        = w_full_q;
    assign w_almost_full = w_af_q;

endmodule

// File: tb/tb_cdc_fifo_wptr_full.sv
// Directed bench for cdc_fifo_wptr_full (ADDR_SIZE=4, margin 2) with an occupancy-count model.
module tb_cdc_fifo_wptr_full;

    logic       w_clk   = 1'b0;
    logic       w_rst_n = 1'b0;
    logic       w_inc   = 1'b0;
    logic [4:0] r_ptr;
    logic [3:0] w_addr;
    logic [4:0] w_ptr;
    logic       w_full;
    logic       w_almost_full;

    int rb = 0;

    function automatic logic [4:0] gray5(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    assign r_ptr = gray5(rb);

    always #5 w_clk = ~w_clk;

    cdc_fifo_wptr_full #(
        .ADDR_SIZE          (4),
        .ALMOST_FULL_MARGIN (2)
    ) dut (
        .w_clk         (w_clk),
        .w_rst_n       (w_rst_n),
        .w_inc         (w_inc),
        .r_ptr         (r_ptr),
        .w_addr        (w_addr),
        .w_ptr         (w_ptr),
        .w_full        (w_full),
        .w_almost_full (w_almost_full)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: count of accepted writes and read position as seen two edges late, all mod 32.
    int m_w  = 0;
    int m_s1 = 0;
    int m_s2 = 0;
    bit m_full = 1'b0;
    bit m_af   = 1'b0;

    always @(posedge w_clk or negedge w_rst_n) begin
        int nw;
        int occ;
        if (!w_rst_n) begin
            m_w    <= 0;
            m_s1   <= 0;
            m_s2   <= 0;
            m_full <= 1'b0;
            m_af   <= 1'b0;
        end else begin
            nw  = (m_w + ((w_inc && !m_full) ? 1 : 0)) % 32;
            occ = (nw - m_s2 + 32) % 32;
            m_w    <= nw;
            m_full <= (occ == 16);
            m_af   <= (occ >= 14);
            m_s2   <= m_s1;
            m_s1   <= rb & 31;
        end
    end

    bit         cmp_en   = 1'b0;
    logic [4:0] prev_ptr = 5'd0;

    always @(negedge w_clk) begin
        if (cmp_en && w_rst_n) begin
            chk("model_addr", int'(w_addr), m_w % 16);
            chk("model_ptr", int'(w_ptr), m_w ^ (m_w >> 1));
            chk("model_full", int'(w_full), int'(m_full));
            chk("model_afull", int'(w_almost_full), int'(m_af));
            if (w_ptr !== prev_ptr)
                chk("ptr_one_bit_step", $countones(w_ptr ^ prev_ptr), 1);
        end
        prev_ptr <= w_ptr;
    end

    initial begin
        bit got_full;

        w_rst_n = 1'b0;
        w_inc   = 1'b0;
        rb      = 0;
        #2;
        chk("rst_addr", int'(w_addr), 0);
        chk("rst_ptr", int'(w_ptr), 0);
        chk("rst_full", int'(w_full), 0);
        chk("rst_afull", int'(w_almost_full), 0);
        cmp_en = 1'b1;
        repeat (2) @(negedge w_clk);
        w_rst_n = 1'b1;

        // Fill from empty: almost-full on write 14, full on write 16.
        w_inc = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge w_clk);
            chk("fill_addr", int'(w_addr), i % 16);
            if (i == 13) chk("afull_before_14", int'(w_almost_full), 0);
            if (i == 14) chk("afull_at_14", int'(w_almost_full), 1);
            if (i == 15) chk("full_before_16", int'(w_full), 0);
            if (i == 16) begin
                chk("full_at_16", int'(w_full), 1);
                chk("ptr_at_16", int'(w_ptr), 'h18);
            end
        end

        // Writes while full are ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge w_clk);
            chk("hold_addr", int'(w_addr), 0);
            chk("hold_ptr", int'(w_ptr), 'h18);
            chk("hold_full", int'(w_full), 1);
        end

        // One read: full clears on the 3rd edge, almost-full stays (occupancy 15).
        w_inc = 1'b0;
        rb    = 1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge w_clk);
            chk("read_full_lag", int'(w_full), (i < 3) ? 1 : 0);
        end
        chk("read_afull_15", int'(w_almost_full), 1);

        // Drain completely, then stream with reads trailing two cycles.
        rb = 16;
        repeat (3) @(negedge w_clk);
        chk("drained_full", int'(w_full), 0);
        chk("drained_afull", int'(w_almost_full), 0);
        w_inc = 1'b1;
        for (int i = 0; i < 70; i++) begin
            rb = (i >= 2) ? (14 + i) : 16;
            @(negedge w_clk);
            chk("stream_full", int'(w_full), 0);
            chk("stream_addr", int'(w_addr), (i + 1) % 16);
        end

        // Fill again with reads frozen, then reset asynchronously between edges.
        got_full = 1'b0;
        for (int i = 0; i < 40 && !got_full; i++) begin
            @(negedge w_clk);
            if (w_full === 1'b1) got_full = 1'b1;
        end
        chk("refill_reaches_full", int'(got_full), 1);
        @(posedge w_clk);
        #2;
        w_rst_n = 1'b0;
        #1;
        chk("async_rst_addr", int'(w_addr), 0);
        chk("async_rst_ptr", int'(w_ptr), 0);
        chk("async_rst_full", int'(w_full), 0);
        chk("async_rst_afull", int'(w_almost_full), 0);
        w_inc = 1'b0;
        rb    = 0;
        repeat (2) @(negedge w_clk);
        w_rst_n = 1'b1;
        chk("post_rst_first_addr", int'(w_addr), 0);

        // Continuous writes with the read pointer advancing every cycle.
        w_inc = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rb = k;
            @(negedge w_clk);
            chk("chase_full", int'(w_full), 0);
            chk("chase_afull", int'(w_almost_full), 0);
            chk("chase_occ_le3", int'(((m_w - m_s2 + 32) % 32) <= 3), 1);
        end

        w_inc = 1'b0;
        @(negedge w_clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
